// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants and helpers for the multi-channel button debouncer.
//
// Contents:
//    CNT_MAX_DEF     default debounce length in ticks (10 ms at a 1 ms tick)
//    HOLD_TICKS_DEF  default long-press hold time in ticks
//    cnt_width()     width of a counter that must represent 0..n-1
//
// Configuration macro used by the files that import this package:
//    BTN_LONG_PRESS_EN  builds the per-channel hold counter and long_press.
// -----------------------------------------------------------------------------
package btn_pkg;

   localparam int CNT_MAX_DEF    = 10;
   localparam int HOLD_TICKS_DEF = 1000;

   // Bits needed to count 0..n-1, never less than one bit so that a
   // degenerate parameter still yields a legal vector.
   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage : btn_pkg

// File: rtl/btn_db_ch.sv
// -----------------------------------------------------------------------------
// btn_db_ch
// One button channel: two-flop synchronizer, tick-based debounce counter,
// registered edge pulses and (optionally) a saturating hold counter that
// raises a single long_press pulse per press.
//
// Parameters:
//    CNT_MAX     consecutive disagreeing ticks needed to accept a new level
//    HOLD_TICKS  ticks the debounced level must stay high for long_press
//
// Ports:
//    clk_100Mhz     in   system clock
//    rst_n          in   asynchronous active-low reset
//    tick           in   one-cycle sample strobe
//    raw            in   raw asynchronous button level, 1 = pressed
//    db             out  debounced level (registered)
//    press          out  one-cycle pulse on debounced 0->1
//    release_pulse  out  one-cycle pulse on debounced 1->0
//                        ("release" is a reserved word in SystemVerilog)
//    long_press     out  one-cycle pulse after HOLD_TICKS ticks held
//
// Configuration: BTN_LONG_PRESS_EN enables the hold counter; without it
// long_press is tied low and HOLD_TICKS only takes part in the range check.
// -----------------------------------------------------------------------------
module btn_db_ch
   import btn_pkg::*;
#(
   parameter int CNT_MAX    = CNT_MAX_DEF,
   parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
   input  logic clk_100Mhz,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic db,
   output logic press,
   output logic release_pulse,
   output logic long_press
);

   // Elaboration-time parameter range checks.
   if (CNT_MAX < 2 || CNT_MAX > 255) begin : g_bad_cnt_max
      $error("btn_db_ch: CNT_MAX must be in 2..255");
   end
   if (HOLD_TICKS < 2 || HOLD_TICKS > 65535) begin : g_bad_hold_ticks
      $error("btn_db_ch: HOLD_TICKS must be in 2..65535");
   end

   localparam int            CW       = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   // ------------------------------------------------------------------
   // Synchronizer
   // ------------------------------------------------------------------
   logic sync_meta;
   logic sync;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours; with blocking '=' the
   // two stages below would collapse into a single flop.
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= raw;        // may go metastable; never used directly
         sync      <= sync_meta;
      end
   end

   // ------------------------------------------------------------------
   // Debounce counter and edge pulses
   // ------------------------------------------------------------------
   logic [CW-1:0] cnt;
   logic          differ;
   logic          accept;

   assign differ = sync ^ db;
   // The tick that completes CNT_MAX consecutive disagreeing samples.
   assign accept = tick & differ & (cnt == CNT_LAST);

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         db            <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         // Pulses are registered on the same edge that updates db, so they
         // are high exactly in the first cycle the new level is visible.
         press         <= accept &  sync;
         release_pulse <= accept & ~sync;
         if (tick) begin
            if (!differ) begin
               cnt <= '0;                 // agreement restarts the count
            end else if (cnt == CNT_LAST) begin
               db  <= sync;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Hold counter and long_press
   // ------------------------------------------------------------------
`ifdef BTN_LONG_PRESS_EN
   localparam int            HW        = cnt_width(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

   logic [HW-1:0] hold;
   logic          hold_done;   // long_press already issued for this press

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         hold       <= '0;
         hold_done  <= 1'b0;
         long_press <= 1'b0;
      end else if (!db) begin
         // Released: discard the hold time and re-arm for the next press.
         hold       <= '0;
         hold_done  <= 1'b0;
         long_press <= 1'b0;
      end else begin
         long_press <= (hold == HOLD_LAST) && !hold_done;
         if (hold == HOLD_LAST) begin
            hold_done <= 1'b1;             // saturated; fire only once
         end else if (tick) begin
            hold <= hold + 1'b1;
         end
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule : btn_db_ch

// File: rtl/btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// btn_debounce_multi
// N_CH independent button debouncers sharing one clock and one tick strobe.
// Each channel is a btn_db_ch instance; channels do not interact, so
// simultaneous events on several channels pulse in the same cycle.
//
// Parameters:
//    N_CH        number of channels (1..32)
//    CNT_MAX     debounce length in ticks (2..255)
//    HOLD_TICKS  long-press hold time in ticks (2..65535)
//
// Ports:
//    clk_100Mhz     in   system clock, the only clock
//    rst_n          in   asynchronous active-low reset
//    tick           in   one-cycle sample strobe, no minimum spacing
//    btn_raw        in   [N_CH] raw button levels, 1 = pressed
//    btn_db         out  [N_CH] debounced levels (registered)
//    press          out  [N_CH] one-cycle pulse per debounced 0->1
//    release_pulse  out  [N_CH] one-cycle pulse per debounced 1->0
//    long_press     out  [N_CH] one-cycle pulse after HOLD_TICKS held
//
// Configuration: define BTN_LONG_PRESS_EN to build the long-press logic;
// otherwise long_press is constant 0.
// -----------------------------------------------------------------------------
module btn_debounce_multi
   import btn_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int CNT_MAX    = CNT_MAX_DEF,
   parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
   input  logic            clk_100Mhz,
   input  logic            rst_n,
   input  logic            tick,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_db,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_press
);

   if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
      $error("btn_debounce_multi: N_CH must be in 1..32");
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      btn_db_ch #(
         .CNT_MAX    (CNT_MAX),
         .HOLD_TICKS (HOLD_TICKS)
      ) u_ch (
         .clk_100Mhz    (clk_100Mhz),
         .rst_n         (rst_n),
         .tick          (tick),
         .raw           (btn_raw[gi]),
         .db            (btn_db[gi]),
         .press         (press[gi]),
         .release_pulse (release_pulse[gi]),
         .long_press    (long_press[gi])
      );
   end

endmodule : btn_debounce_multi

// File: tb/tb_btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_multi
// Self-checking bench for btn_debounce_multi (N_CH=4, CNT_MAX=4,
// HOLD_TICKS=8). Directed scenarios followed by random stimulus; every
// cycle's outputs are compared with a behavioural model that works in
// terms of "raw seen two clocks late", "run of disagreeing tick samples"
// and "ticks held since the press".
// Honours BTN_LONG_PRESS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_btn_debounce_multi;

   localparam int N_CH       = 4;
   localparam int CNT_MAX    = 4;
   localparam int HOLD_TICKS = 8;
   localparam int TICK_DIV   = 10;
`ifdef BTN_LONG_PRESS_EN
   localparam int LP_EXP = 1;
`else
   localparam int LP_EXP = 0;
`endif

   logic            clk_100Mhz = 1'b0;
   logic            rst_n      = 1'b0;
   logic            tick       = 1'b0;
   logic [N_CH-1:0] btn_raw    = '0;
   logic [N_CH-1:0] btn_db;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] release_pulse;
   logic [N_CH-1:0] long_press;

   always #5 clk_100Mhz = ~clk_100Mhz;

   btn_debounce_multi #(
      .N_CH       (N_CH),
      .CNT_MAX    (CNT_MAX),
      .HOLD_TICKS (HOLD_TICKS)
   ) dut (
      .clk_100Mhz    (clk_100Mhz),
      .rst_n         (rst_n),
      .tick          (tick),
      .btn_raw       (btn_raw),
      .btn_db        (btn_db),
      .press         (press),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   // ---------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------
   int    vectors     = 0;
   int    miscompares = 0;
   string scen        = "init";

   int press_cnt [N_CH];
   int rel_cnt   [N_CH];
   int long_cnt  [N_CH];
   int both_cnt;              // cycles with press == 4'b1001

   // ---------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------
   logic [N_CH-1:0] m_db, m_press, m_rel, m_long;
   logic [N_CH-1:0] raw_hist [$];  // raw values of the last two edges
   int              run_len  [N_CH];
   int              held     [N_CH];
   bit              lp_pend  [N_CH];

   task automatic model_reset();
      m_db = '0; m_press = '0; m_rel = '0; m_long = '0;
      raw_hist.delete();
      raw_hist.push_back('0);
      raw_hist.push_back('0);
      for (int c = 0; c < N_CH; c++) begin
         run_len[c] = 0; held[c] = 0; lp_pend[c] = 1'b0;
      end
   endtask

   // Outputs after a clock edge, given the inputs present before it.
   task automatic model_edge(input logic [N_CH-1:0] raw, input logic tk);
      logic [N_CH-1:0] seen;
      seen = raw_hist.pop_front();   // raw as it was two edges ago
      raw_hist.push_back(raw);
      m_press = '0; m_rel = '0; m_long = '0;
      for (int c = 0; c < N_CH; c++) begin
`ifdef BTN_LONG_PRESS_EN
         m_long[c] = lp_pend[c] & m_db[c];
`endif
         lp_pend[c] = 1'b0;
         if (!m_db[c]) held[c] = 0;
         else if (tk) begin
            held[c]++;
            if (held[c] == HOLD_TICKS) lp_pend[c] = 1'b1;
         end
         if (tk) begin
            if (seen[c] == m_db[c]) run_len[c] = 0;
            else begin
               run_len[c]++;
               if (run_len[c] == CNT_MAX) begin
                  m_db[c]    = seen[c];
                  run_len[c] = 0;
                  if (seen[c]) m_press[c] = 1'b1;
                  else         m_rel[c]   = 1'b1;
               end
            end
         end
      end
   endtask

   // ---------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------
   task automatic check(input string tag, input logic [N_CH-1:0] got,
                        input logic [N_CH-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s/%s: observed %b expected %b", scen, tag, got, exp);
      end
   endtask

   task automatic check_n(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s/%s: observed %0d expected %0d", scen, tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      check("btn_db",        btn_db,        m_db);
      check("press",         press,         m_press);
      check("release",       release_pulse, m_rel);
      check("long_press",    long_press,    m_long);
   endtask

   task automatic clear_tallies();
      for (int c = 0; c < N_CH; c++) begin
         press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      end
      both_cnt = 0;
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
   task automatic cycle(input logic [N_CH-1:0] raw, input logic tk);
      btn_raw = raw;
      tick    = tk;
      @(posedge clk_100Mhz);
      if (!rst_n) model_reset();
      else        model_edge(raw, tk);
      #1;
      check_outputs();
      for (int c = 0; c < N_CH; c++) begin
         press_cnt[c] += int'(press[c]);
         rel_cnt[c]   += int'(release_pulse[c]);
         long_cnt[c]  += int'(long_press[c]);
      end
      if (press === 4'b1001) both_cnt++;
   endtask

   // n tick periods with a fixed raw level; tick on the last cycle of each.
   task automatic run_ticks(input int n, input logic [N_CH-1:0] raw);
      for (int t = 0; t < n; t++)
         for (int j = 0; j < TICK_DIV; j++)
            cycle(raw, j == TICK_DIV - 1);
   endtask

   // ---------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------
   initial begin
      logic [N_CH-1:0] r;
      logic [N_CH-1:0] flip;

      // Reset state
      scen = "reset";
      model_reset();
      clear_tallies();
      for (int i = 0; i < 5; i++) cycle(N_CH'($urandom), 1'b1);
      rst_n = 1'b1;

      // Clean press on channel 0, then release
      scen = "clean_press";
      clear_tallies();
      run_ticks(6, 4'b0001);
      check_n("press0_pulses", press_cnt[0], 1);
      check_n("db0_high", int'(btn_db[0]), 1);
      scen = "clean_release";
      clear_tallies();
      run_ticks(6, 4'b0000);
      check_n("release0_pulses", rel_cnt[0], 1);
      check_n("press0_pulses", press_cnt[0], 0);

      // Bounce on channel 1: 3 high, 1 low, 3 high -> rejected
      scen = "bounce";
      clear_tallies();
      run_ticks(3, 4'b0010);
      run_ticks(1, 4'b0000);
      run_ticks(3, 4'b0010);
      check_n("db1_still_low", int'(btn_db[1]), 0);
      run_ticks(5, 4'b0010);
      check_n("press1_pulses", press_cnt[1], 1);
      run_ticks(6, 4'b0000);
      check_n("release1_pulses", rel_cnt[1], 1);

      // Long press on channel 2
      scen = "long_press";
      clear_tallies();
      run_ticks(24, 4'b0100);
      check_n("long2_pulses", long_cnt[2], LP_EXP);
      check_n("press2_pulses", press_cnt[2], 1);
      run_ticks(6, 4'b0000);
      check_n("release2_pulses", rel_cnt[2], 1);
      check_n("long2_no_repeat", long_cnt[2], LP_EXP);

      // Simultaneous press on channels 0 and 3
      scen = "simultaneous";
      clear_tallies();
      run_ticks(6, 4'b1001);
      check_n("press_1001_cycles", both_cnt, 1);
      run_ticks(6, 4'b0000);
      check_n("release0_pulses", rel_cnt[0], 1);
      check_n("release3_pulses", rel_cnt[3], 1);

      // Reset in the middle of a debounce count (count = 3)
      scen = "reset_mid_count";
      clear_tallies();
      run_ticks(3, 4'b0001);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      for (int i = 0; i < 4; i++) cycle(4'b0001, 1'b1);
      rst_n = 1'b1;
      run_ticks(3, 4'b0001);
      check_n("db0_not_yet", int'(btn_db[0]), 0);
      check_n("no_pulse_after_reset", press_cnt[0], 0);
      run_ticks(2, 4'b0001);
      check_n("press0_after_restart", press_cnt[0], 1);
      run_ticks(6, 4'b0000);

      // Random levels and random (possibly adjacent) ticks
      scen = "random";
      r = '0;
      for (int i = 0; i < 4000; i++) begin
         flip = '0;
         for (int c = 0; c < N_CH; c++)
            flip[c] = ($urandom_range(0, 29) == 0);
         r ^= flip;
         cycle(r, $urandom_range(0, 3) == 0);
      end

      // Long holds with random tick spacing
      scen = "random_hold";
      for (int i = 0; i < 600; i++) cycle(4'b1111, $urandom_range(0, 2) == 0);
      for (int i = 0; i < 300; i++) cycle(4'b0000, $urandom_range(0, 1) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_btn_debounce_multi
